// File: rtl/rx_decrc_engine_ble.sv
// rx_decrc_engine_ble: BLE receive CRC checker, forwards payload, strips CRC.
// Optional dewhitening LFSR and whiten_init port under RX_DECRC_DEWHITEN_EN.
module rx_decrc_engine_ble #(
  parameter int                 CRC_LEN  = 24,
  parameter logic [CRC_LEN-1:0] CRC_POLY = 24'h00065B,
  parameter int                 LEN_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CRC_LEN-1:0] crc_init,
  input  logic [LEN_W-1:0]   n_bits,
`ifdef RX_DECRC_DEWHITEN_EN
  input  logic [6:0]         whiten_init,
`endif
  input  logic               valid_in,
  input  logic               data_bit,
  output logic               data_out,
  output logic               valid_out,
  output logic               busy,
  output logic               done,
  output logic               crc_ok,
  output logic [LEN_W-1:0]   bit_count
);

  localparam int CW = $clog2(CRC_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CRC,
    S_DONE
  } state_t;

  state_t             state;
  logic [CRC_LEN-1:0] crc_reg;
  logic [CRC_LEN-1:0] crc_nx;
  logic [LEN_W-1:0]   pay_cnt;
  logic [CW-1:0]      crc_cnt;
  logic               pipe_v;
  logic               pipe_d;
  logic               din;
  logic               acc;

`ifdef RX_DECRC_DEWHITEN_EN
  logic [6:0] wh;
  logic [6:0] wh_nx;

  assign din   = data_bit ^ wh[6];
  assign wh_nx = {wh[5], wh[4], wh[3] ^ wh[6],
                  wh[2:0], wh[6]};
`else
  assign din = data_bit;
`endif

  assign acc = valid_in &&
               (state == S_PAYLOAD ||
                state == S_CRC);

  assign crc_nx = {crc_reg[CRC_LEN-2:0], 1'b0}
                ^ ((din ^ crc_reg[CRC_LEN-1])
                   ? CRC_POLY : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      crc_reg   <= '0;
      pay_cnt   <= '0;
      crc_cnt   <= '0;
      pipe_v    <= 1'b0;
      pipe_d    <= 1'b0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      bit_count <= '0;
`ifdef RX_DECRC_DEWHITEN_EN
      wh        <= '0;
`endif
    end else begin
      // Second stage of the two-edge payload path
      data_out  <= pipe_v & pipe_d;
      valid_out <= pipe_v;
      pipe_v    <= 1'b0;
      pipe_d    <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        crc_reg   <= crc_init;
        pay_cnt   <= n_bits;
        crc_cnt   <= CW'(CRC_LEN);
        crc_ok    <= 1'b0;
        bit_count <= '0;
        busy      <= 1'b1;
        state     <= (n_bits == '0)
                     ? S_CRC : S_PAYLOAD;
`ifdef RX_DECRC_DEWHITEN_EN
        wh        <= whiten_init;
`endif
      end else begin
        if (acc) begin
          crc_reg <= crc_nx;
`ifdef RX_DECRC_DEWHITEN_EN
          wh      <= wh_nx;
`endif
        end
        unique case (state)
          S_IDLE: begin
            busy <= 1'b0;
          end
          S_PAYLOAD: begin
            if (valid_in) begin
              pipe_v    <= 1'b1;
              pipe_d    <= din;
              pay_cnt   <= pay_cnt - LEN_W'(1);
              bit_count <= bit_count + LEN_W'(1);
              if (pay_cnt == LEN_W'(1))
                state <= S_CRC;
            end
          end
          S_CRC: begin
            if (valid_in) begin
              crc_cnt <= crc_cnt - CW'(1);
              if (crc_cnt == CW'(1))
                state <= S_DONE;
            end
          end
          S_DONE: begin
            done   <= 1'b1;
            crc_ok <= (crc_reg == '0);
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_decrc_engine_ble.sv
// tb_rx_decrc_engine_ble: random frames vs polynomial-division CRC model.
// Covers empty payload, corruption, gaps, abort, reset and dewhitening.
module tb_rx_decrc_engine_ble;

  localparam logic [23:0] POLY = 24'h00065B;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] crc_init = '0;
  logic [15:0] n_bits = '0;
  logic        valid_in = 1'b0;
  logic        data_bit = 1'b0;
  logic        data_out;
  logic        valid_out;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic [15:0] bit_count;
`ifdef RX_DECRC_DEWHITEN_EN
  logic [6:0]  whiten_init = '0;
`endif

  always #5 clk = ~clk;

  rx_decrc_engine_ble dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .crc_init   (crc_init),
    .n_bits     (n_bits),
`ifdef RX_DECRC_DEWHITEN_EN
    .whiten_init(whiten_init),
`endif
    .valid_in   (valid_in),
    .data_bit   (data_bit),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .bit_count  (bit_count)
  );

  typedef struct {
    int cyc;
    bit b;
  } ent_t;

  ent_t       exp_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  bit         drv_pay = 1'b0;
  bit         drv_clean = 1'b0;
  bit         ok_seen = 1'b0;
  logic [6:0] wl = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  // Residual of init*x^T + R(x)*x^24 mod (x^24 + POLY)
  function automatic logic [23:0] crc_rem(
    input logic [23:0] init, input bit bits[$]);
    bit p[320];
    int t;
    logic [23:0] r;
    t = bits.size();
    foreach (p[i]) p[i] = 1'b0;
    for (int j = 0; j < 24; j++) p[j + t] = init[j];
    for (int i = 0; i < t; i++)
      p[24 + t - 1 - i] = p[24 + t - 1 - i] ^ bits[i];
    for (int d = t + 23; d >= 24; d--)
      if (p[d]) begin
        p[d] = 1'b0;
        for (int j = 0; j < 24; j++)
          p[d - 24 + j] = p[d - 24 + j] ^ POLY[j];
      end
    for (int j = 0; j < 24; j++) r[j] = p[j];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset && valid_in && drv_pay)
      exp_q.push_back('{cyc, drv_clean});
  end

  always @(negedge clk) begin
    if (reset) begin
      if (valid_out) begin
        if (exp_q.size() == 0)
          chk("fwd_extra", 1, 0);
        else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("data_out", data_out, e.b);
          chk("fwd_lat", cyc, e.cyc + 1);
        end
      end
      if (done) begin
        done_cnt++;
        ok_seen = crc_ok;
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    start    = 1'b0;
    valid_in = 1'b0;
    data_bit = 1'($urandom);
    drv_pay  = 1'b0;
  endtask

  task automatic send_bit(input bit b, input bit pay,
                          input int gap);
    if (gap == 1) idle();
    else if (gap == 2)
      while ($urandom_range(0, 2) == 0) idle();
    @(negedge clk);
    start     = 1'b0;
    valid_in  = 1'b1;
    drv_pay   = pay;
    drv_clean = b;
    data_bit  = b ^ wl[6];
`ifdef RX_DECRC_DEWHITEN_EN
    wl = {wl[5], wl[4], wl[3] ^ wl[6], wl[2:0], wl[6]};
`endif
  endtask

  task automatic do_start(input logic [23:0] init,
                          input int n,
                          input logic [6:0] w,
                          input bit vin);
    @(negedge clk);
    start    = 1'b1;
    crc_init = init;
    n_bits   = 16'(n);
    valid_in = vin;
    data_bit = 1'($urandom);
    drv_pay  = 1'b0;
`ifdef RX_DECRC_DEWHITEN_EN
    whiten_init = w;
    wl = w;
`else
    wl = w & 7'h00;
`endif
  endtask

  task automatic run_frame(input int n,
                           input logic [23:0] init,
                           input logic [31:0] pat,
                           input int corrupt,
                           input int gap,
                           input logic [6:0] w,
                           input int abort_at);
    bit clean[$];
    logic [23:0] c;
    bit exp_ok;
    done_cnt = 0;
    for (int i = 0; i < n; i++)
      clean.push_back(n <= 32 ? pat[n - 1 - i]
                              : 1'($urandom));
    c = crc_rem(init, clean);
    for (int j = 23; j >= 0; j--) clean.push_back(c[j]);
    if (corrupt >= 0) clean[corrupt] = ~clean[corrupt];
    exp_ok = (crc_rem(init, clean) == 24'h0);
    if (abort_at >= 0) begin
      do_start(~init, abort_at + 3, ~w, 1'b0);
      for (int i = 0; i < abort_at; i++)
        send_bit(1'($urandom), 1'b1, gap);
    end
    do_start(init, n, w, abort_at >= 0);
    @(posedge clk);
    #1;
    chk("busy_start", busy, 1);
    chk("crc_ok_clr", crc_ok, 0);
    for (int i = 0; i < clean.size(); i++)
      send_bit(clean[i], i < n, gap);
    repeat (9) idle();
    chk("done_once", done_cnt, 1);
    chk("crc_ok_done", ok_seen, exp_ok);
    chk("crc_ok_hold", crc_ok, exp_ok);
    chk("bit_count", bit_count, n);
    chk("busy_end", busy, 0);
    chk("fwd_all", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_bit_count", bit_count, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) idle();

    run_frame(0, 24'h555555, 0, -1, 0, 7'h53, -1);
    run_frame(0, 24'h555555, 0, 10, 0, 7'h53, -1);
    run_frame(8, 24'($urandom), 32'hA5, -1, 1,
              7'h53, -1);
    run_frame(8, 24'($urandom), $urandom, -1, 0,
              7'($urandom), 5);

    done_cnt = 0;
    do_start(24'h123456, 4, 7'h11, 1'b0);
    for (int i = 0; i < 14; i++)
      send_bit(1'($urandom), i < 4, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_data_out", data_out, 0);
    chk("mid_valid_out", valid_out, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_crc_ok", crc_ok, 0);
    chk("mid_bit_count", bit_count, 0);
    exp_q.delete();
    idle();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) idle();
    chk("mid_no_done", done_cnt, 0);

    run_frame(1, 24'($urandom), $urandom, -1, 0,
              7'($urandom), -1);
    run_frame(40, 24'($urandom), 0, -1, 2,
              7'($urandom), -1);
    for (int k = 0; k < 10; k++) begin
      automatic int n = $urandom_range(0, 60);
      automatic int cb = -1;
      if ($urandom_range(0, 2) == 0)
        cb = $urandom_range(0, n + 23);
      run_frame(n, 24'($urandom), $urandom, cb, 2,
                7'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
